// File: rtl/board_pkg.sv
// Shared board definitions for the bomb controller and the board matrix stage.
// Contents:
//   - board geometry (origin in pixels, tile size, columns, rows)
//   - object codes stored in the board matrix
//   - bomb FSM state type
//   - within_radius(): magnitude test on a signed 6-bit tile difference
package board_pkg;

  localparam logic [10:0] X_MATRIX   = 11'h020;
  localparam logic [10:0] Y_MATRIX   = 11'h060;
  localparam int          TILE_ORDER = 5;
  localparam logic [4:0]  COLUMNS    = 5'd17;
  localparam logic [3:0]  ROWS       = 4'd11;

  // Board extent in pixels, measured from the board origin.
  localparam logic [10:0] BOARD_W = {6'd0, COLUMNS} << TILE_ORDER;
  localparam logic [10:0] BOARD_H = {7'd0, ROWS} << TILE_ORDER;

  typedef enum logic [2:0] {
    BG      = 3'd0,
    PERSIST = 3'd1,
    STURDY  = 3'd2,
    BRITTLE = 3'd3,
    MINE    = 3'd4
  } obj_code_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    BLAST = 2'd2
  } bomb_state_t;

  // True when |diff| <= radius, with diff read as two's complement.
  function automatic logic within_radius(input logic [5:0] diff, input logic [2:0] radius);
    logic [5:0] mag;
    mag = diff[5] ? (6'd0 - diff) : diff;
    return (mag <= {3'd0, radius});
  endfunction

endpackage

// File: rtl/bomb_controller_tile_decode.sv
// tile_decode: maps the current pixel to a board tile.
// Ports:
//   pixel_x_i, pixel_y_i  in  11  current pixel
//   on_board_o            out 1   pixel lies inside the board rectangle
//   tc_o                  out 5   tile column (valid when on_board_o)
//   tr_o                  out 4   tile row    (valid when on_board_o)
module tile_decode
  import board_pkg::*;
(
  input  logic [10:0] pixel_x_i,
  input  logic [10:0] pixel_y_i,
  output logic        on_board_o,
  output logic [4:0]  tc_o,
  output logic [3:0]  tr_o
);

  logic [10:0] rel_x_s;
  logic [10:0] rel_y_s;

  // Pixel offset from the board origin, range test and tile index.
  always_comb begin
    rel_x_s    = pixel_x_i - X_MATRIX;
    rel_y_s    = pixel_y_i - Y_MATRIX;
    // Left/top of the origin the subtraction wraps, so both bounds are tested explicitly.
    on_board_o = (pixel_x_i >= X_MATRIX) && (rel_x_s < BOARD_W) &&
                 (pixel_y_i >= Y_MATRIX) && (rel_y_s < BOARD_H);
    tc_o       = rel_x_s[TILE_ORDER +: 5];
    tr_o       = rel_y_s[TILE_ORDER +: 4];
  end

endmodule

// File: rtl/bomb_controller.sv
// bomb_controller: owns the player's single bomb (drop, fuse, blast).
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   frame_tick             one-cycle pulse per video frame
//   drop_bomb              request to place the bomb at the player tile
//   player_col, player_row player tile
//   pixel_x, pixel_y       current pixel
//   explosion              pixel inside the active blast cross
//   bomb_dr                pixel inside the armed bomb tile
//   bomb_busy              bomb is armed or blasting
//   detonated              one-cycle pulse on the ARMED->BLAST transition
module bomb_controller
  import board_pkg::*;
#(
  parameter logic [7:0] FUSE_FRAMES  = 8'd120,
  parameter logic [7:0] BLAST_FRAMES = 8'd30,
  parameter logic [2:0] RADIUS       = 3'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        drop_bomb,
  input  logic [4:0]  player_col,
  input  logic [3:0]  player_row,
  input  logic [10:0] pixel_x,
  input  logic [10:0] pixel_y,
  output logic        explosion,
  output logic        bomb_dr,
  output logic        bomb_busy,
  output logic        detonated
);

  bomb_state_t state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  bomb_col_q, bomb_col_d;
  logic [3:0]  bomb_row_q, bomb_row_d;
  logic        det_q, det_d;

  logic        on_board_s;
  logic [4:0]  tc_s;
  logic [3:0]  tr_s;
  logic        tick_dec_s;
  logic [5:0]  dc_s;
  logic [5:0]  dr_s;

  tile_decode u_tile_decode (
    .pixel_x_i  (pixel_x),
    .pixel_y_i  (pixel_y),
    .on_board_o (on_board_s),
    .tc_o       (tc_s),
    .tr_o       (tr_s)
  );

  // State, frame counter, latched tile and detonation pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      bomb_col_q <= 5'd0;
      bomb_row_q <= 4'd0;
      det_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bomb_col_q <= bomb_col_d;
      bomb_row_q <= bomb_row_d;
      det_q      <= det_d;
    end
  end

  // Next-state logic: accept drops, count ticks through fuse and blast.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bomb_col_d = bomb_col_q;
    bomb_row_d = bomb_row_q;
    det_d      = 1'b0;
    // Counter only moves while nonzero so it can never wrap.
    tick_dec_s = frame_tick && (cnt_q != 8'd0);
    case (state_q)
      IDLE: begin
        // A tick in the accepting cycle is ignored: the counter is loaded, not decremented.
        if (drop_bomb && (player_col < COLUMNS) && (player_row < ROWS)) begin
          state_d    = ARMED;
          cnt_d      = FUSE_FRAMES;
          bomb_col_d = player_col;
          bomb_row_d = player_row;
        end else begin
          state_d    = IDLE;
        end
      end
      ARMED: begin
        if (tick_dec_s && (cnt_q == 8'd1)) begin
          state_d = BLAST;
          cnt_d   = BLAST_FRAMES;
          det_d   = 1'b1;
        end else if (tick_dec_s) begin
          cnt_d   = cnt_q - 8'd1;
        end else begin
          cnt_d   = cnt_q;
        end
      end
      BLAST: begin
        if (tick_dec_s && (cnt_q == 8'd1)) begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end else if (tick_dec_s) begin
          cnt_d   = cnt_q - 8'd1;
        end else begin
          cnt_d   = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // Per-pixel outputs; blast cross arms use signed 6-bit tile differences, clipped by on_board.
  always_comb begin
    dc_s      = {1'b0, tc_s} - {1'b0, bomb_col_q};
    dr_s      = {2'b00, tr_s} - {2'b00, bomb_row_q};
    bomb_busy = (state_q != IDLE);
    detonated = det_q;
    bomb_dr   = (state_q == ARMED) && on_board_s &&
                (tc_s == bomb_col_q) && (tr_s == bomb_row_q);
    explosion = (state_q == BLAST) && on_board_s &&
                (((tr_s == bomb_row_q) && within_radius(dc_s, RADIUS)) ||
                 ((tc_s == bomb_col_q) && within_radius(dr_s, RADIUS)));
  end

endmodule

// File: tb/tb_bomb_controller.sv
// Self-checking bench for bomb_controller: directed sequences with
// constant tables plus randomized stimulus against a tick-counting model.
module tb_bomb_controller;

  localparam int FUSE  = 120;
  localparam int BLST  = 30;
  localparam int RAD   = 2;
  localparam int NCOL  = 17;
  localparam int NROW  = 11;
  localparam int X0    = 32;
  localparam int Y0    = 96;
  localparam int TS    = 32;

  logic        clk;
  logic        rst_n;
  logic        frame_tick;
  logic        drop_bomb;
  logic [4:0]  player_col;
  logic [3:0]  player_row;
  logic [10:0] pixel_x;
  logic [10:0] pixel_y;
  logic        explosion;
  logic        bomb_dr;
  logic        bomb_busy;
  logic        detonated;

  int n_cmp;
  int n_fail;

  // Model: a bomb is "active" from acceptance; it is armed for the first
  // FUSE ticks seen after acceptance and blasting for the next BLST ticks.
  int m_active;
  int m_ticks;
  int m_col;
  int m_row;
  int m_det;

  typedef struct {
    logic [10:0] px;
    logic [10:0] py;
    logic        exp_expl;
  } pix_vec_t;

  pix_vec_t tab[$];

  bomb_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .drop_bomb  (drop_bomb),
    .player_col (player_col),
    .player_row (player_row),
    .pixel_x    (pixel_x),
    .pixel_y    (pixel_y),
    .explosion  (explosion),
    .bomb_dr    (bomb_dr),
    .bomb_busy  (bomb_busy),
    .detonated  (detonated)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [10:0] tx(input int c);
    return 11'(X0 + c * TS + 16);
  endfunction

  function automatic logic [10:0] ty(input int r);
    return 11'(Y0 + r * TS + 16);
  endfunction

  function automatic int on_board(input int x, input int y);
    return (x >= X0 && x < X0 + NCOL * TS && y >= Y0 && y < Y0 + NROW * TS) ? 1 : 0;
  endfunction

  function automatic logic m_expl(input int x, input int y);
    int c, r, dc, dr;
    if (m_active == 0 || m_ticks < FUSE || on_board(x, y) == 0) return 1'b0;
    c  = (x - X0) / TS;
    r  = (y - Y0) / TS;
    dc = (c > m_col) ? c - m_col : m_col - c;
    dr = (r > m_row) ? r - m_row : m_row - r;
    return ((r == m_row && dc <= RAD) || (c == m_col && dr <= RAD)) ? 1'b1 : 1'b0;
  endfunction

  function automatic logic m_bomb_dr(input int x, input int y);
    if (m_active == 0 || m_ticks >= FUSE || on_board(x, y) == 0) return 1'b0;
    return (((x - X0) / TS) == m_col && ((y - Y0) / TS) == m_row) ? 1'b1 : 1'b0;
  endfunction

  task automatic model_reset();
    m_active = 0; m_ticks = 0; m_col = 0; m_row = 0; m_det = 0;
  endtask

  task automatic model_edge(input logic d, input logic t, input int c, input int r);
    int det_next;
    det_next = 0;
    if (m_active == 0) begin
      if (d && c < NCOL && r < NROW) begin
        m_active = 1; m_ticks = 0; m_col = c; m_row = r;
      end
    end else if (t) begin
      m_ticks++;
      if (m_ticks == FUSE) det_next = 1;
      if (m_ticks == FUSE + BLST) m_active = 0;
    end
    m_det = det_next;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: apply inputs after the falling edge, compare against
  // the model mid-cycle, then advance the model on the rising edge.
  task automatic drive(input logic d, input logic t, input int c, input int r,
                       input logic [10:0] x, input logic [10:0] y);
    @(negedge clk);
    drop_bomb  = d;
    frame_tick = t;
    player_col = 5'(c);
    player_row = 4'(r);
    pixel_x    = x;
    pixel_y    = y;
    #1;
    chk("model_explosion", explosion, m_expl(int'(x), int'(y)));
    chk("model_bomb_dr",   bomb_dr,   m_bomb_dr(int'(x), int'(y)));
    chk("model_busy",      bomb_busy, (m_active != 0) ? 1'b1 : 1'b0);
    chk("model_detonated", detonated, (m_det != 0) ? 1'b1 : 1'b0);
    @(posedge clk);
    model_edge(d, t, c, r);
  endtask

  initial begin
    int c, r, xi, yi;
    n_cmp = 0;
    n_fail = 0;
    model_reset();
    rst_n = 1'b0; frame_tick = 1'b0; drop_bomb = 1'b0;
    player_col = 5'd0; player_row = 4'd0;
    pixel_x = tx(0); pixel_y = ty(0);
    #3;
    chk("reset_explosion", explosion, 1'b0);
    chk("reset_bomb_dr",   bomb_dr,   1'b0);
    chk("reset_busy",      bomb_busy, 1'b0);
    chk("reset_detonated", detonated, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Out-of-range drops in IDLE are ignored.
    drive(1'b1, 1'b0, 17, 3, tx(4), ty(3));
    #2 chk("oob_col_ignored", bomb_busy, 1'b0);
    drive(1'b1, 1'b0, 4, 11, tx(4), ty(3));
    #2 chk("oob_row_ignored", bomb_busy, 1'b0);

    // Drop at (4,3) with a coincident tick that must not count.
    drive(1'b1, 1'b1, 4, 3, 11'h0A0, 11'h0C0);
    #2 chk("armed_busy", bomb_busy, 1'b1);
    for (int i = 0; i < FUSE - 1; i++) begin
      drive(1'b0, 1'b1, 4, 3, 11'h0A0, 11'h0C0);
      drive(1'b0, 1'b0, 4, 3, 11'h0A0, 11'h0C0);
      if (i == 50) drive(1'b1, 1'b0, 6, 6, 11'h0A0, 11'h0C0);
      if (i == 60) drive(1'b1, 1'b0, 17, 3, 11'h0A0, 11'h0C0);
    end
    #2;
    chk("pre_det_detonated", detonated, 1'b0);
    chk("pre_det_bomb_dr",   bomb_dr,   1'b1);
    chk("pre_det_busy",      bomb_busy, 1'b1);
    drive(1'b0, 1'b1, 4, 3, 11'h0A0, 11'h0C0);
    #2;
    chk("tick120_detonated", detonated, 1'b1);
    chk("tick120_bomb_dr",   bomb_dr,   1'b0);
    chk("tick120_explosion", explosion, 1'b1);

    // Blast cross around (4,3).
    tab.delete();
    for (int k = 2; k <= 6; k++) tab.push_back('{tx(k), ty(3), 1'b1});
    tab.push_back('{tx(4), ty(1), 1'b1});
    tab.push_back('{tx(4), ty(2), 1'b1});
    tab.push_back('{tx(4), ty(4), 1'b1});
    tab.push_back('{tx(4), ty(5), 1'b1});
    tab.push_back('{tx(7), ty(3), 1'b0});
    tab.push_back('{tx(5), ty(4), 1'b0});
    tab.push_back('{tx(1), ty(3), 1'b0});
    tab.push_back('{tx(4), ty(6), 1'b0});
    tab.push_back('{11'h010, 11'h070, 1'b0});
    foreach (tab[i]) begin
      drive(1'b1, 1'b0, 2, 2, tab[i].px, tab[i].py);
      #2 chk("cross_4_3", explosion, tab[i].exp_expl);
    end
    chk("det_single_pulse", detonated, 1'b0);

    // Held drop through the blast rearms on the first IDLE cycle.
    for (int i = 0; i < BLST; i++) drive(1'b1, 1'b1, 0, 0, tx(0), ty(0));
    #2 chk("blast_end_idle", bomb_busy, 1'b0);
    drive(1'b1, 1'b0, 0, 0, tx(0), ty(0));
    #2;
    chk("rearm_busy",    bomb_busy, 1'b1);
    chk("rearm_bomb_dr", bomb_dr,   1'b1);
    for (int i = 0; i < FUSE; i++) drive(1'b0, 1'b1, 0, 0, tx(0), ty(0));

    // Blast at (0,0) is clipped at the board corner.
    tab.delete();
    tab.push_back('{tx(0), ty(0), 1'b1});
    tab.push_back('{tx(1), ty(0), 1'b1});
    tab.push_back('{tx(2), ty(0), 1'b1});
    tab.push_back('{tx(0), ty(1), 1'b1});
    tab.push_back('{tx(0), ty(2), 1'b1});
    tab.push_back('{tx(3), ty(0), 1'b0});
    tab.push_back('{tx(0), ty(3), 1'b0});
    tab.push_back('{tx(16), ty(0), 1'b0});
    tab.push_back('{tx(15), ty(0), 1'b0});
    tab.push_back('{tx(0), ty(10), 1'b0});
    tab.push_back('{tx(0), ty(9), 1'b0});
    tab.push_back('{tx(1), ty(1), 1'b0});
    tab.push_back('{11'h01F, ty(0), 1'b0});
    foreach (tab[i]) begin
      drive(1'b0, 1'b0, 0, 0, tab[i].px, tab[i].py);
      #2 chk("cross_0_0", explosion, tab[i].exp_expl);
    end

    // Asynchronous reset mid-blast.
    drive(1'b0, 1'b0, 0, 0, tx(0), ty(0));
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_explosion", explosion, 1'b0);
    chk("async_rst_busy",      bomb_busy, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2 chk("post_rst_idle", bomb_busy, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      c = int'($urandom_range(18));
      r = int'($urandom_range(12));
      if ($urandom_range(3) != 0) begin
        xi = X0 + (m_col + int'($urandom_range(6)) - 3) * TS + int'($urandom_range(31));
        yi = Y0 + (m_row + int'($urandom_range(6)) - 3) * TS + int'($urandom_range(31));
      end else begin
        xi = int'($urandom_range(700));
        yi = int'($urandom_range(500));
      end
      drive(($urandom_range(7) == 0) ? 1'b1 : 1'b0, 1'(($urandom_range(1))),
            c, r, 11'(xi), 11'(yi));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
